pool_spike_gen: RTL and testbench
=================================

# pool_spike_gen

Downstream stage of the sum-pooling block. Once pooling has written per-window channel sums into the pooled feature-map memory, this block scans every pooled coordinate and thresholds each channel. It emits one spike event per coordinate that fires, then writes the reset/leaked membrane value back through the arbiter. It is started and paused through the same enable/active/done control scheme as the other convolution-pipeline stages.

## Interface
Parameters:
- CHANNELS, DEFAULT_CHANNELS, channel lanes per memory word
- BITS_PER_CHANNEL, DEFAULT_NEURON_BITS, unsigned width of each lane
- IMG_WIDTH, DEFAULT_IMG_WIDTH, pre-pooling width; pooled width OUT_W = IMG_WIDTH/2
- IMG_HEIGHT, DEFAULT_IMG_HEIGHT, pre-pooling height; pooled height OUT_H = IMG_HEIGHT/2
- THRESHOLD, 100, fire when lane >= THRESHOLD
- DECAY_SHIFT, 2, leak shift amount; 0 disables leak

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- enable  in  1  run/pause request
- active  out  1  high while a coordinate is in flight
- done  out  1  one-cycle pulse when the scan completes
- read_req  out  1  memory read strobe
- coord_get  out  vec2_t  read coordinate
- data_out  in  CHANNELS*BITS_PER_CHANNEL  read data, valid the cycle after read_req
- write_req  out  1  memory write strobe
- coord_wtr  out  vec2_t  write coordinate
- data_in  out  CHANNELS*BITS_PER_CHANNEL  write data
- event_valid  out  1  spike event valid
- event_ready  in  1  consumer accepts the event
- event_coord  out  vec2_t  pooled coordinate of the event
- event_spikes  out  CHANNELS  per-channel fire mask

## Operation
- FSM states: IDLE, READ, EVAL, WRITE, EMIT, DONE.
- IDLE → READ when enable=1. Coordinate counters are cleared to (0,0) on entry.
- READ: read_req=1, coord_get=(x,y). Next state is EVAL.
- EVAL: register data_out and compute the per-lane result.
  - Spike when v >= THRESHOLD; the new value is then 0.
  - Otherwise the new value is v − (v >> DECAY_SHIFT).
  - Result width is BITS_PER_CHANNEL, with no overflow possible.
  - Next state is WRITE.
- WRITE: write_req=1, coord_wtr=(x,y), data_in=new word. Next state:
  - EMIT if any lane fired;
  - else DONE if (x,y) is the last coordinate;
  - else READ if enable=1, otherwise IDLE-pause.
- EMIT: event_valid=1, with event_coord/event_spikes held stable until event_ready=1. On acceptance the next state follows the same rules as WRITE's non-EMIT branches.
- Pause: enable is sampled only at coordinate boundaries (leaving WRITE or EMIT).
  - If enable=0 at that point, the FSM enters IDLE with counters retained. Re-enable resumes at the next coordinate.
  - Counters are cleared only after DONE or reset.
- Scan order is row-major: x increments first and wraps at OUT_W−1 to 0 with y+1. The last coordinate is (OUT_W−1, OUT_H−1).
- DONE: done=1 for one cycle, then IDLE with counters cleared.
- active=1 in READ, EVAL, WRITE and EMIT.

## Timing
- Reset (synchronous) clears state to IDLE and counters to 0. All outputs are 0: active, done, read_req, write_req, event_valid, coord_get, coord_wtr, data_in, event_coord, event_spikes.
- Reset mid-scan (including EMIT) forces IDLE on the next edge. The pending event is dropped and nothing is written.
- Memory read latency is fixed at 1 cycle.
- Enable sampled high in IDLE at edge T gives READ in cycle T+1, EVAL in T+2 and WRITE in T+3.
- A non-firing coordinate takes 3 cycles. A firing coordinate takes 4 + (ready stall cycles).
- The 2x2 pooled map with no spikes has READs at T+1/4/7/10, the last WRITE at T+12 and done at T+13.
- read_req and write_req are never high in the same cycle.
- event_valid never drops without event_ready.

## Structure
- snn_interfaces_pkg: reuse vec2_t and DEFAULT_*.
- Add to snn_interfaces_pkg: a spike_event_t typedef (coord + spike mask) and a pool_fire_state_t enum.
- Sub-module: pool_neuron_lane, a combinational single-lane threshold/leak unit, generated CHANNELS times.
- The top level holds only the FSM, counters and registers.

## Test plan
Common configuration: CHANNELS=2, BITS=8, IMG 4x4 (pooled 2x2), THRESHOLD=100, DECAY_SHIFT=2.
- Reset: assert reset for 2 cycles with enable=1 → every output 0, no read_req.
- No-spike scan: memory all lanes 40, event_ready=1 → four writes of 30/30 at (0,0),(1,0),(0,1),(1,1); no event_valid; done pulse exactly 13 cycles after enable.
- Threshold edge: at (1,0) ch1=120, ch0=100, other coordinates 99 → one event with coord (1,0) and spikes=2'b11, written 0/0; the other coordinates are written 75/75.
- Backpressure: spike at (0,0) with event_ready low for 5 cycles → event_valid and its fields stable; no read_req until acceptance; the scan then completes normally.
- Pause: enable dropped during EVAL of (0,1) → that coordinate's write completes, then active=0. Re-enable 10 cycles later → the next READ is at (1,1); 4 writes in total, then done.
- Reset during EMIT → IDLE next cycle with event_valid=0. Re-enable restarts at (0,0).

Source files
------------

// File: rtl/snn_interfaces_pkg.sv
// Shared types for the convolution/pooling spike pipeline: coordinates, spike
// events, FSM encodings and default geometry.
package snn_interfaces_pkg;

  localparam int COORD_W             = 8;
  localparam int MAX_CHANNELS        = 32;
  localparam int DEFAULT_CHANNELS    = 2;
  localparam int DEFAULT_NEURON_BITS = 8;
  localparam int DEFAULT_IMG_WIDTH   = 4;
  localparam int DEFAULT_IMG_HEIGHT  = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t                   coord;
    logic [MAX_CHANNELS-1:0] spikes;
  } spike_event_t;

  typedef enum logic [2:0] {
    PF_IDLE,
    PF_READ,
    PF_EVAL,
    PF_WRITE,
    PF_EMIT,
    PF_DONE
  } pool_fire_state_t;

endpackage

// File: rtl/pool_neuron_lane.sv
// Single-lane threshold/leak unit: fires and resets to zero at or above
// THRESHOLD, otherwise leaks by v >> DECAY_SHIFT.
module pool_neuron_lane #(
  parameter int BITS_PER_CHANNEL = 8,
  parameter int THRESHOLD        = 100,
  parameter int DECAY_SHIFT      = 2
) (
  input  logic [BITS_PER_CHANNEL-1:0] v,
  output logic                        spike,
  output logic [BITS_PER_CHANNEL-1:0] v_next
);

  // Subtracting a right-shifted copy can never underflow; shift 0 means no leak.
  function automatic logic [BITS_PER_CHANNEL-1:0] leak(input logic [BITS_PER_CHANNEL-1:0] x);
    if (DECAY_SHIFT == 0)
      return x;
    return x - (x >> DECAY_SHIFT);
  endfunction

  always_comb begin
    spike  = (32'(v) >= 32'(THRESHOLD));
    v_next = spike ? '0 : leak(v);
  end

endmodule

// File: rtl/pool_spike_gen.sv
// Scans the pooled feature map, thresholds every channel lane, writes back the
// reset/leaked membrane word and emits one spike event per firing coordinate.
module pool_spike_gen
  import snn_interfaces_pkg::*;
#(
  parameter int CHANNELS         = DEFAULT_CHANNELS,
  parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
  parameter int IMG_WIDTH        = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT       = DEFAULT_IMG_HEIGHT,
  parameter int THRESHOLD        = 100,
  parameter int DECAY_SHIFT      = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  output logic                                 active,
  output logic                                 done,
  output logic                                 read_req,
  output vec2_t                                coord_get,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] data_out,
  output logic                                 write_req,
  output vec2_t                                coord_wtr,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] data_in,
  output logic                                 event_valid,
  input  logic                                 event_ready,
  output vec2_t                                event_coord,
  output logic [CHANNELS-1:0]                  event_spikes
);

  localparam int OUT_W  = IMG_WIDTH / 2;
  localparam int OUT_H  = IMG_HEIGHT / 2;
  localparam int WORD_W = CHANNELS * BITS_PER_CHANNEL;

  pool_fire_state_t    state;
  vec2_t               cnt;
  vec2_t               cnt_nxt;
  logic                is_last;
  logic                boundary;
  logic [WORD_W-1:0]   word_p1;
  logic [CHANNELS-1:0] fire_p1;
  logic [CHANNELS-1:0] fire_p2;

  // ---- stage p1: lane evaluation on the word returned by memory ----
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_neuron_lane #(
      .BITS_PER_CHANNEL (BITS_PER_CHANNEL),
      .THRESHOLD        (THRESHOLD),
      .DECAY_SHIFT      (DECAY_SHIFT)
    ) u_lane (
      .v      (data_out[c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]),
      .spike  (fire_p1[c]),
      .v_next (word_p1[c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL])
    );
  end

  always_comb begin
    is_last = (cnt.x == COORD_W'(OUT_W - 1)) && (cnt.y == COORD_W'(OUT_H - 1));
    cnt_nxt = cnt;
    if (cnt.x == COORD_W'(OUT_W - 1)) begin
      cnt_nxt.x = '0;
      cnt_nxt.y = cnt.y + 1'b1;
    end else begin
      cnt_nxt.x = cnt.x + 1'b1;
    end
    boundary = ((state == PF_WRITE) && !(|fire_p2)) ||
               ((state == PF_EMIT) && event_ready);
  end

  // ---- stage p2: write-back, event hand-off and scan control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PF_IDLE;
      cnt          <= '0;
      active       <= 1'b0;
      done         <= 1'b0;
      read_req     <= 1'b0;
      write_req    <= 1'b0;
      event_valid  <= 1'b0;
      coord_get    <= '0;
      coord_wtr    <= '0;
      data_in      <= '0;
      event_coord  <= '0;
      event_spikes <= '0;
      fire_p2      <= '0;
    end else begin
      read_req  <= 1'b0;
      write_req <= 1'b0;
      done      <= 1'b0;
      case (state)
        PF_IDLE: if (enable) begin
          state     <= PF_READ;
          active    <= 1'b1;
          read_req  <= 1'b1;
          coord_get <= cnt;
        end
        PF_READ: state <= PF_EVAL;
        PF_EVAL: begin
          state     <= PF_WRITE;
          write_req <= 1'b1;
          coord_wtr <= cnt;
          data_in   <= word_p1;
          fire_p2   <= fire_p1;
        end
        PF_WRITE: if (|fire_p2) begin
          state        <= PF_EMIT;
          event_valid  <= 1'b1;
          event_coord  <= cnt;
          event_spikes <= fire_p2;
        end
        PF_EMIT: if (event_ready) event_valid <= 1'b0;
        PF_DONE: state <= PF_IDLE;
        default: state <= PF_IDLE;
      endcase

      // Coordinate boundary: the only place enable can pause the scan.
      if (boundary) begin
        if (is_last) begin
          state  <= PF_DONE;
          done   <= 1'b1;
          active <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt_nxt;
          if (enable) begin
            state     <= PF_READ;
            read_req  <= 1'b1;
            coord_get <= cnt_nxt;
          end else begin
            state  <= PF_IDLE;
            active <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_spike_gen.sv
// Directed bench for pool_spike_gen on a 2x2 pooled map, 2 lanes of 8 bits.
module tb_pool_spike_gen;
  import snn_interfaces_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        event_ready = 1'b0;
  logic        active, done, read_req, write_req, event_valid;
  vec2_t       coord_get, coord_wtr, event_coord;
  logic [15:0] data_out = '0;
  logic [15:0] data_in;
  logic [1:0]  event_spikes;

  pool_spike_gen #(
    .CHANNELS(2), .BITS_PER_CHANNEL(8), .IMG_WIDTH(4), .IMG_HEIGHT(4),
    .THRESHOLD(100), .DECAY_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .active(active), .done(done),
    .read_req(read_req), .coord_get(coord_get), .data_out(data_out),
    .write_req(write_req), .coord_wtr(coord_wtr), .data_in(data_in),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_coord(event_coord), .event_spikes(event_spikes)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4];

  always @(posedge clk)
    if (read_req) data_out <= mem[int'(coord_get.y) * 2 + int'(coord_get.x)];

  int          cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, ev_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  int          rd_cyc [64];
  vec2_t       rd_co [64];
  vec2_t       wr_co [64];
  logic [15:0] wr_d [64];
  vec2_t       ev_co [64];
  logic [1:0]  ev_s [64];
  int          viol_rw = 0, viol_hold = 0;
  logic        hold_q = 1'b0, rst_q = 1'b1;
  vec2_t       h_co = '0;
  logic [1:0]  h_s = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_req === 1'b1) begin
      rd_co[rd_cnt] <= coord_get; rd_cyc[rd_cnt] <= cyc; rd_cnt <= rd_cnt + 1;
    end
    if (write_req === 1'b1) begin
      wr_co[wr_cnt] <= coord_wtr; wr_d[wr_cnt] <= data_in; wr_cnt <= wr_cnt + 1;
    end
    if (event_valid === 1'b1 && event_ready) begin
      ev_co[ev_cnt] <= event_coord; ev_s[ev_cnt] <= event_spikes; ev_cnt <= ev_cnt + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1; last_done_cyc <= cyc;
    end
    if (read_req === 1'b1 && write_req === 1'b1) viol_rw <= viol_rw + 1;
    if (hold_q && !rst_q &&
        (event_valid !== 1'b1 || event_coord != h_co || event_spikes != h_s))
      viol_hold <= viol_hold + 1;
    hold_q <= (event_valid === 1'b1) && !event_ready;
    h_co   <= event_coord;
    h_s    <= event_spikes;
    rst_q  <= reset;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic vec2_t mkc(input int x, input int y);
    vec2_t c;
    c.x = COORD_W'(x);
    c.y = COORD_W'(y);
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 4; i++) mem[i] = w;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt == base && k < 100) begin step(1); k++; end
    enable = 1'b0;
    chk(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_ev(input string tag);
    int k = 0;
    while (event_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk(tag, 32'(event_valid), 32'd1);
  endtask

  int xs [4] = '{0, 1, 0, 1};
  int ys [4] = '{0, 0, 1, 1};
  int t0, rb, wb, eb, db;

  initial begin
    // Reset held with enable high
    enable = 1'b1;
    step(2);
    @(negedge clk);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_read_req", 32'(read_req), 0);
    chk("rst_write_req", 32'(write_req), 0);
    chk("rst_event_valid", 32'(event_valid), 0);
    chk("rst_coord_get", 32'(coord_get), 0);
    chk("rst_coord_wtr", 32'(coord_wtr), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_event_coord", 32'(event_coord), 0);
    chk("rst_event_spikes", 32'(event_spikes), 0);
    chk("rst_no_reads", 32'(rd_cnt), 0);
    enable = 1'b0;
    reset  = 1'b0;
    step(2);

    // No-spike scan: 40 leaks to 30, done 13 cycles after enable
    fill(16'h2828);
    event_ready = 1'b1;
    rb = rd_cnt; wb = wr_cnt; eb = ev_cnt; db = done_cnt;
    t0 = cyc;
    enable = 1'b1;
    wait_done(db, "ns_done");
    chk("ns_done_cycle", 32'(last_done_cyc - t0), 32'd13);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ns_rd_cyc%0d", i), 32'(rd_cyc[rb + i] - t0), 32'(1 + 3 * i));
      chk($sformatf("ns_wr_co%0d", i), 32'(wr_co[wb + i]), 32'(mkc(xs[i], ys[i])));
      chk($sformatf("ns_wr_d%0d", i), 32'(wr_d[wb + i]), 32'h1E1E);
    end
    chk("ns_wr_cnt", 32'(wr_cnt - wb), 32'd4);
    chk("ns_no_event", 32'(ev_cnt - eb), 32'd0);
    step(3);

    // Threshold edge: 100 and 120 fire at (1,0); 99 leaks to 75
    fill(16'h6363);
    mem[1] = 16'h7864;
    rb = rd_cnt; wb = wr_cnt; eb = ev_cnt; db = done_cnt;
    enable = 1'b1;
    wait_done(db, "th_done");
    chk("th_ev_cnt", 32'(ev_cnt - eb), 32'd1);
    chk("th_ev_coord", 32'(ev_co[eb]), 32'(mkc(1, 0)));
    chk("th_ev_spikes", 32'(ev_s[eb]), 32'b11);
    chk("th_wr_cnt", 32'(wr_cnt - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("th_wr_co%0d", i), 32'(wr_co[wb + i]), 32'(mkc(xs[i], ys[i])));
      chk($sformatf("th_wr_d%0d", i), 32'(wr_d[wb + i]), (i == 1) ? 32'h0000 : 32'h4B4B);
    end
    step(3);

    // Backpressure: ch1=150 fires at (0,0), ch0=10 leaks to 8
    fill(16'h2828);
    mem[0] = 16'h960A;
    event_ready = 1'b0;
    rb = rd_cnt; wb = wr_cnt; eb = ev_cnt; db = done_cnt;
    enable = 1'b1;
    wait_ev("bp_ev_up");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(event_valid), 32'd1);
      chk($sformatf("bp_coord%0d", i), 32'(event_coord), 32'(mkc(0, 0)));
      chk($sformatf("bp_spikes%0d", i), 32'(event_spikes), 32'b10);
      chk($sformatf("bp_no_read%0d", i), 32'(read_req), 32'd0);
      @(negedge clk);
    end
    chk("bp_reads_stalled", 32'(rd_cnt - rb), 32'd1);
    event_ready = 1'b1;
    wait_done(db, "bp_done");
    chk("bp_ev_cnt", 32'(ev_cnt - eb), 32'd1);
    chk("bp_ev_spikes", 32'(ev_s[eb]), 32'b10);
    chk("bp_wr_d0", 32'(wr_d[wb]), 32'h0008);
    chk("bp_wr_d3", 32'(wr_d[wb + 3]), 32'h1E1E);
    chk("bp_wr_cnt", 32'(wr_cnt - wb), 32'd4);
    step(3);

    // Pause during EVAL of (0,1), resume at (1,1)
    fill(16'h2828);
    rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    enable = 1'b1;
    begin
      int k = 0;
      while (!(read_req === 1'b1 && coord_get == mkc(0, 1)) && k < 50) begin
        @(negedge clk); k++;
      end
      chk("pa_read01", 32'(coord_get), 32'(mkc(0, 1)));
    end
    step(1);
    enable = 1'b0;
    step(4);
    chk("pa_inactive", 32'(active), 32'd0);
    chk("pa_wr3", 32'(wr_cnt - wb), 32'd3);
    step(6);
    chk("pa_rd_held", 32'(rd_cnt - rb), 32'd3);
    enable = 1'b1;
    wait_done(db, "pa_done");
    chk("pa_rd_cnt", 32'(rd_cnt - rb), 32'd4);
    chk("pa_resume_co", 32'(rd_co[rb + 3]), 32'(mkc(1, 1)));
    chk("pa_wr_cnt", 32'(wr_cnt - wb), 32'd4);
    chk("pa_wr_last", 32'(wr_co[wb + 3]), 32'(mkc(1, 1)));
    step(3);

    // Reset during EMIT, then restart from (0,0)
    fill(16'hC8C8);
    event_ready = 1'b0;
    enable = 1'b1;
    wait_ev("re_ev_up");
    wb = wr_cnt;
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("re_valid_low", 32'(event_valid), 32'd0);
    chk("re_inactive", 32'(active), 32'd0);
    reset = 1'b0;
    step(3);
    chk("re_no_write", 32'(wr_cnt - wb), 32'd0);
    fill(16'h2828);
    event_ready = 1'b1;
    rb = rd_cnt; db = done_cnt;
    enable = 1'b1;
    wait_done(db, "re_done");
    chk("re_first_co", 32'(rd_co[rb]), 32'(mkc(0, 0)));
    chk("re_wr_cnt", 32'(wr_cnt - wb), 32'd4);
    step(2);

    chk("rd_wr_overlap", 32'(viol_rw), 32'd0);
    chk("event_hold", 32'(viol_hold), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
